fpga_operand_entry: RTL

- Input-side front end for the DE2 ALU bring-up harness. It debounces the raw push-buttons and edge-detects them.
- A state machine assembles two 32-bit operands and a 4-bit ALU opcode from the slide switches in sequence.
- The finished operation set goes to the ALU datapath over a valid/ready handshake. This replaces direct switch/key wiring to the ALU ports.

---
 rtl/fpga_operand_entry.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fpga_operand_entry.sv
// fpga_operand_entry: key synchronizer/debouncer and operand assembly FSM
// feeding the DE2 ALU datapath over a valid/ready handshake.
module fpga_operand_entry #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    output logic [31:0] port_a,
    output logic [31:0] port_b,
    output logic [3:0]  aluop,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [2:0]  state_led
);

    typedef enum logic [2:0] {
        ST_A_LO    = 3'd0,
        ST_A_HI    = 3'd1,
        ST_B_LO    = 3'd2,
        ST_B_HI    = 3'd3,
        ST_OP      = 3'd4,
        ST_PRESENT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [CNT_W-1:0] r_cnt [4];
    logic [3:0]       r_db;
    logic [3:0]       r_db_d;
    logic [3:0]       w_press;
    logic             w_enter;
    logic             w_clear;
    logic             w_unused;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_port_a;
    logic [31:0]      r_port_b;
    logic [3:0]       r_aluop;
    logic             r_valid;
    logic [31:0]      w_port_a_nxt;
    logic [31:0]      w_port_b_nxt;
    logic [3:0]       w_aluop_nxt;
    logic             w_valid_nxt;
    logic [15:0]      w_sext;

    // Two-flop synchronizer on the raw active-low keys
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= KEY;
            r_sync2 <= r_sync1;
        end
    end

    // Per-key debounce: accept a level only after it differs long enough
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
            r_db <= '1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] != r_db[i]) begin
                    if (r_cnt[i] == LP_CNT_LAST) begin
                        r_db[i]  <= r_sync2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // Delayed debounced level for falling-edge (press) detection
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_db_d <= '1;
        end else begin
            r_db_d <= r_db;
        end
    end

    assign w_press  = r_db_d & ~r_db;
    assign w_enter  = w_press[0];
    assign w_clear  = w_press[1];
    assign w_unused = ^{w_press[3:2], SW[17]};
    assign w_sext   = {16{SW[15]}};

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_A_LO;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and operand update; clear overrides enter and handshake
    always_comb begin
        w_state_nxt  = r_state;
        w_port_a_nxt = r_port_a;
        w_port_b_nxt = r_port_b;
        w_aluop_nxt  = r_aluop;
        w_valid_nxt  = r_valid;
        if (w_clear) begin
            w_state_nxt  = ST_A_LO;
            w_port_a_nxt = '0;
            w_port_b_nxt = '0;
            w_aluop_nxt  = '0;
            w_valid_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                ST_A_LO: begin
                    if (w_enter) begin
                        w_port_a_nxt[15:0] = SW[15:0];
                        if (SW[16]) begin
                            w_port_a_nxt[31:16] = w_sext;
                            w_state_nxt = ST_B_LO;
                        end else begin
                            w_state_nxt = ST_A_HI;
                        end
                    end
                end
                ST_A_HI: begin
                    if (w_enter) begin
                        w_port_a_nxt[31:16] = SW[15:0];
                        w_state_nxt = ST_B_LO;
                    end
                end
                ST_B_LO: begin
                    if (w_enter) begin
                        w_port_b_nxt[15:0] = SW[15:0];
                        if (SW[16]) begin
                            w_port_b_nxt[31:16] = w_sext;
                            w_state_nxt = ST_OP;
                        end else begin
                            w_state_nxt = ST_B_HI;
                        end
                    end
                end
                ST_B_HI: begin
                    if (w_enter) begin
                        w_port_b_nxt[31:16] = SW[15:0];
                        w_state_nxt = ST_OP;
                    end
                end
                ST_OP: begin
                    if (w_enter) begin
                        w_aluop_nxt = SW[3:0];
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (r_valid && op_ready) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ST_A_LO;
                    end
                end
                default: begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_A_LO;
                end
            endcase
        end
    end

    // Operand, opcode and valid registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_port_a <= '0;
            r_port_b <= '0;
            r_aluop  <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_port_a <= w_port_a_nxt;
            r_port_b <= w_port_b_nxt;
            r_aluop  <= w_aluop_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    assign port_a    = r_port_a;
    assign port_b    = r_port_b;
    assign aluop     = r_aluop;
    assign op_valid  = r_valid;
    assign state_led = r_state;

endmodule
